note_sequencer: RTL

//  Song sequencer that sits directly upstream of the note ROM: it steps the ROM address at a

---
 rtl/note_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// note_sequencer -- steps a note ROM at a fixed tempo and turns each code into a held
// note number plus gate / strobe for a downstream tone generator.
//
// Optional build macro: SEQ_LOOP_EN
//    defined   : end-of-song (END_CODE or address wrap) restarts the song at address 0
//    undefined : end-of-song parks the sequencer in DONE until start or stop
//
// Ports
//    clk          system clock
//    rst          asynchronous reset, active-high
//    start        begins playback from address 0 when idle or done
//    stop         aborts playback, back to idle (wins over start)
//    rom_addr     registered ROM address
//    rom_note     ROM data, valid one clock after rom_addr changes
//    note         current MIDI note number, held across rests
//    gate         high while a note sounds
//    note_strobe  one-cycle pulse when a new non-rest note is latched
//    playing      high in FETCH / LATCH / HOLD
//    done         high in DONE
module note_sequencer #(
   parameter int          ADDR_W     = 9,
   parameter int          TICK_DIV   = 1_800_000,
   parameter int          GAP_CYCLES = 120_000,
   parameter logic [7:0]  REST_CODE  = 8'd255,
   parameter logic [7:0]  END_CODE   = 8'd1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_note,
   output logic [7:0]        note,
   output logic              gate,
   output logic              note_strobe,
   output logic              playing,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LATCH = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

`ifdef SEQ_LOOP_EN
   localparam logic LOOP_EN = 1'b1;
`else
   localparam logic LOOP_EN = 1'b0;
`endif

   localparam int                CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
   // Gate output is registered, so it is cleared one count early to be low
   // exactly from count TICK_DIV-GAP_CYCLES onward.
   localparam logic [CNT_W-1:0]  GAP_PRE   = CNT_W'(TICK_DIV - GAP_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
   localparam state_t            END_NEXT  = LOOP_EN ? S_FETCH : S_DONE;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [7:0]          note_q, note_d;
   logic                gate_q, gate_d;
   logic                strobe_q, strobe_d;
   logic                playing_q, playing_d;
   logic                done_q, done_d;
   logic                step_end_s;
   logic                song_end_s;

   assign step_end_s = (cnt_q == CNT_LAST);
   assign song_end_s = (rom_note == END_CODE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; stop overrides everything
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  state_d = start ? S_FETCH : S_IDLE;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: state_d = song_end_s ? END_NEXT : S_HOLD;
            S_HOLD: begin
               if (step_end_s) begin
                  // Incrementing past the last address counts as end of song
                  state_d = (rom_addr_q == ADDR_LAST) ? END_NEXT : S_FETCH;
               end else begin
                  state_d = S_HOLD;
               end
            end
            S_DONE:  state_d = start ? S_FETCH : S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      cnt_d      = cnt_q;
      rom_addr_d = rom_addr_q;
      note_d     = note_q;
      gate_d     = gate_q;
      strobe_d   = 1'b0;
      if (stop) begin
         cnt_d      = CNT_ZERO;
         rom_addr_d = ADDR_ZERO;
         gate_d     = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               gate_d = 1'b0;
               cnt_d  = CNT_ZERO;
               if (start) begin
                  rom_addr_d = ADDR_ZERO;
               end else begin
                  rom_addr_d = rom_addr_q;
               end
            end
            S_FETCH: cnt_d = cnt_q + CNT_ONE;
            S_LATCH: begin
               cnt_d = cnt_q + CNT_ONE;
               if (song_end_s) begin
                  gate_d = 1'b0;
                  if (LOOP_EN) begin
                     rom_addr_d = ADDR_ZERO;
                     cnt_d      = CNT_ZERO;
                  end else begin
                     rom_addr_d = rom_addr_q;
                  end
               end else if (rom_note == REST_CODE) begin
                  gate_d = 1'b0;
               end else begin
                  note_d   = rom_note;
                  gate_d   = 1'b1;
                  strobe_d = 1'b1;
               end
            end
            S_HOLD: begin
               if (step_end_s) begin
                  cnt_d  = CNT_ZERO;
                  gate_d = 1'b0;
                  // When looping the increment wraps to zero naturally; otherwise hold the
                  // last address while parked in DONE.
                  if (rom_addr_q == ADDR_LAST && !LOOP_EN) begin
                     rom_addr_d = rom_addr_q;
                  end else begin
                     rom_addr_d = rom_addr_q + ADDR_ONE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (cnt_q >= GAP_PRE) begin
                     gate_d = 1'b0;
                  end else begin
                     gate_d = gate_q;
                  end
               end
            end
            default: begin
               cnt_d      = CNT_ZERO;
               rom_addr_d = ADDR_ZERO;
               gate_d     = 1'b0;
            end
         endcase
      end
      playing_d = (state_d == S_FETCH) || (state_d == S_LATCH) || (state_d == S_HOLD);
      done_d    = (state_d == S_DONE);
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= CNT_ZERO;
         rom_addr_q <= ADDR_ZERO;
         note_q     <= 8'd0;
         gate_q     <= 1'b0;
         strobe_q   <= 1'b0;
         playing_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         rom_addr_q <= rom_addr_d;
         note_q     <= note_d;
         gate_q     <= gate_d;
         strobe_q   <= strobe_d;
         playing_q  <= playing_d;
         done_q     <= done_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign note        = note_q;
   assign gate        = gate_q;
   assign note_strobe = strobe_q;
   assign playing     = playing_q;
   assign done        = done_q;

endmodule
